sea_iter_core: RTL and testbench

//  Iterative SEA Feistel cipher core: runs NUM_ROUNDS rounds over a 2*HALF_W-bit

---
 rtl/sea_iter_core_pkg.sv | 71 +++++++
 rtl/sea_iter_core_if.sv | 37 +++
 rtl/sea_iter_core_round.sv | 54 +++++
 rtl/sea_iter_core.sv | 152 +++++++++++++++
 tb/tb_sea_iter_core.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sea_iter_core_pkg.sv
`default_nettype none
// ============================================================================
// Module : sea_iter_core_pkg
// Purpose: Shared definitions for the iterative SEA cipher core: FSM state
//          encoding, mode constants, the 3-bit S-box and width-parametrised
//          rotation helpers.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package sea_iter_core_pkg;

  // Rotation helpers work on a wide carrier vector; callers zero-extend their
  // operand into it and truncate the result back to their own width.
  localparam int MAX_W = 256;
  typedef logic [MAX_W-1:0] wide_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  function automatic logic [2:0] sbox3(input logic [2:0] x);
    logic [2:0] y;
    case (x)
      3'd0:    y = 3'd0;
      3'd1:    y = 3'd5;
      3'd2:    y = 3'd6;
      3'd3:    y = 3'd7;
      3'd4:    y = 3'd4;
      3'd5:    y = 3'd3;
      3'd6:    y = 3'd1;
      default: y = 3'd2;
    endcase
    return y;
  endfunction

  // Rotate the low w bits of x left by n (n may be any integer, taken mod w).
  // Bits of x above w must be zero; bits of the result above w are zero.
  function automatic wide_t rotl(input wide_t x, input int w, input int n);
    wide_t mask;
    wide_t y;
    int    amt;
    amt  = ((n % w) + w) % w;
    mask = '1;
    mask = mask >> (MAX_W - w);
    y    = (x << amt) | (x >> (w - amt));
    return y & mask;
  endfunction

  function automatic wide_t rotr(input wide_t x, input int w, input int n);
    return rotl(x, w, -n);
  endfunction

  function automatic wide_t rot1(input wide_t x, input int w);
    return rotl(x, w, 1);
  endfunction

  function automatic wide_t rotw(input wide_t x, input int w, input int word_w);
    return rotl(x, w, word_w);
  endfunction

  function automatic wide_t rotwr(input wide_t x, input int w, input int word_w);
    return rotr(x, w, word_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sea_iter_core_if.sv
`default_nettype none
// ============================================================================
// Module : sea_iter_core_if
// Purpose: Valid/ready bus of the SEA cipher core (input block side, result
//          side and busy status).
// Ports  : in_valid/in_ready/in_mode/in_l/in_r/in_key   block request
//          out_valid/out_ready/out_l/out_r              result
//          busy                                          core occupied
//          modport slave  = core side, modport master = requester side
// Rev    : 1.0  initial release
// ============================================================================
interface sea_iter_core_if #(
  parameter int HALF_W = 48
);
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [HALF_W-1:0] in_l;
  logic [HALF_W-1:0] in_r;
  logic [HALF_W-1:0] in_key;
  logic              out_valid;
  logic              out_ready;
  logic [HALF_W-1:0] out_l;
  logic [HALF_W-1:0] out_r;
  logic              busy;

  modport slave (
    input  in_valid, in_mode, in_l, in_r, in_key, out_ready,
    output in_ready, out_valid, out_l, out_r, busy
  );

  modport master (
    output in_valid, in_mode, in_l, in_r, in_key, out_ready,
    input  in_ready, out_valid, out_l, out_r, busy
  );
endinterface
`default_nettype wire

// File: rtl/sea_iter_core_round.sv
`default_nettype none
// ============================================================================
// Module : sea_iter_core_round
// Purpose: One combinational SEA Feistel round, encrypt or decrypt.
// Ports  : mode         0 = encrypt, 1 = decrypt
//          a, b         current left / right halves
//          k            round key
//          l_nxt, r_nxt next left / right halves
// Rev    : 1.0  initial release
// ============================================================================
module sea_iter_core_round
  import sea_iter_core_pkg::*;
#(
  parameter int HALF_W = 48,
  parameter int WORD_W = 8
) (
  input  logic              mode,
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic [HALF_W-1:0] k,
  output logic [HALF_W-1:0] l_nxt,
  output logic [HALF_W-1:0] r_nxt
);

  logic [HALF_W-1:0] w_f_in;
  logic [HALF_W-1:0] w_s;
  logic [HALF_W-1:0] w_f;

  // Decrypt mixes the key into the left half, encrypt into the right half;
  // the F function itself (S-box then 1-bit rotate) is shared.
  assign w_f_in = (mode == MODE_DEC) ? (a ^ k) : (b ^ k);

  generate
    for (genvar gi = 0; gi < HALF_W / 3; gi++) begin : g_sbox
      assign w_s[3*gi +: 3] = sbox3(w_f_in[3*gi +: 3]);
    end
  endgenerate

  assign w_f = HALF_W'(rot1(wide_t'(w_s), HALF_W));

  always_comb begin
    l_nxt = b;
    r_nxt = a;
    if (mode == MODE_DEC) begin
      l_nxt = HALF_W'(rotw(wide_t'(w_f ^ b), HALF_W, WORD_W));
      r_nxt = a;
    end else begin
      l_nxt = b;
      r_nxt = HALF_W'(rotwr(wide_t'(a), HALF_W, WORD_W)) ^ w_f;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sea_iter_core.sv
`default_nettype none
// ============================================================================
// Module : sea_iter_core
// Purpose: Iterative SEA Feistel cipher engine. Accepts one block at a time,
//          runs NUM_ROUNDS rounds at UNROLL rounds per clock, then holds the
//          result until the consumer takes it.
// Ports  : clk   clock, rising edge
//          rst   asynchronous reset, active-high
//          bus   sea_iter_core_if.slave (request, result, busy)
// Rev    : 1.0  initial release
// ============================================================================
module sea_iter_core
  import sea_iter_core_pkg::*;
#(
  parameter int HALF_W     = 48,
  parameter int WORD_W     = 8,
  parameter int NUM_ROUNDS = 16,
  parameter int UNROLL     = 1,
  parameter int KEY_ROT    = 1
) (
  input  logic            clk,
  input  logic            rst,
  sea_iter_core_if.slave  bus
);

  localparam int c_ctr_w    = $clog2(NUM_ROUNDS + 1);
  localparam int c_kstep    = (UNROLL * KEY_ROT) % HALF_W;
  localparam int c_dec_init = ((NUM_ROUNDS - 1) * KEY_ROT) % HALF_W;

  state_t             r_state;
  logic [c_ctr_w-1:0] r_ctr;
  logic [HALF_W-1:0]  r_l;
  logic [HALF_W-1:0]  r_r;
  logic [HALF_W-1:0]  r_key;
  logic               r_mode;
  logic [HALF_W-1:0]  r_out_l;
  logic [HALF_W-1:0]  r_out_r;
  logic               r_out_valid;
  logic               r_in_ready;
  logic               r_busy;

  logic [HALF_W-1:0]  w_a [0:UNROLL];
  logic [HALF_W-1:0]  w_b [0:UNROLL];
  logic [HALF_W-1:0]  w_k [0:UNROLL-1];
  logic [HALF_W-1:0]  w_key_nxt;
  logic [HALF_W-1:0]  w_key_load;
  logic [c_ctr_w-1:0] w_ctr_nxt;

  // r_key always holds the key of round r_ctr, so each unrolled stage only
  // needs a fixed rotation of it: forward for encrypt (key rotates left as
  // rounds advance), backward for decrypt (schedule is walked in reverse).
  assign w_a[0] = r_l;
  assign w_b[0] = r_r;

  generate
    for (genvar gs = 0; gs < UNROLL; gs++) begin : g_stage
      localparam int c_off = (gs * KEY_ROT) % HALF_W;

      assign w_k[gs] = (r_mode == MODE_DEC)
                     ? HALF_W'(rotr(wide_t'(r_key), HALF_W, c_off))
                     : HALF_W'(rotl(wide_t'(r_key), HALF_W, c_off));

      sea_iter_core_round #(
        .HALF_W (HALF_W),
        .WORD_W (WORD_W)
      ) u_round (
        .mode  (r_mode),
        .a     (w_a[gs]),
        .b     (w_b[gs]),
        .k     (w_k[gs]),
        .l_nxt (w_a[gs+1]),
        .r_nxt (w_b[gs+1])
      );
    end
  endgenerate

  assign w_key_nxt = (r_mode == MODE_DEC)
                   ? HALF_W'(rotr(wide_t'(r_key), HALF_W, c_kstep))
                   : HALF_W'(rotl(wide_t'(r_key), HALF_W, c_kstep));

  // Decrypt starts from the last encrypt round key.
  assign w_key_load = (bus.in_mode == MODE_DEC)
                    ? HALF_W'(rotl(wide_t'(bus.in_key), HALF_W, c_dec_init))
                    : bus.in_key;

  assign w_ctr_nxt = r_ctr + c_ctr_w'(UNROLL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ctr       <= '0;
      r_l         <= '0;
      r_r         <= '0;
      r_key       <= '0;
      r_mode      <= MODE_ENC;
      r_out_l     <= '0;
      r_out_r     <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_l        <= bus.in_l;
            r_r        <= bus.in_r;
            r_key      <= w_key_load;
            r_mode     <= bus.in_mode;
            r_ctr      <= '0;
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          r_l   <= w_a[UNROLL];
          r_r   <= w_b[UNROLL];
          r_key <= w_key_nxt;
          r_ctr <= w_ctr_nxt;
          if (w_ctr_nxt == c_ctr_w'(NUM_ROUNDS)) begin
            r_out_l     <= w_a[UNROLL];
            r_out_r     <= w_b[UNROLL];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_l     = r_out_l;
  assign bus.out_r     = r_out_r;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sea_iter_core.sv
`default_nettype none
// ============================================================================
// Module : tb_sea_iter_core
// Purpose: Directed self-checking bench for sea_iter_core. Three instances:
//          NUM_ROUNDS=1, defaults, and UNROLL=4; one shared driver steered
//          to the selected instance.
// Ports  : none
// Rev    : 1.0  initial release
// ============================================================================
module tb_sea_iter_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [1:0]  sel;
  logic        drv_valid;
  logic        drv_mode;
  logic        drv_ready;
  logic [47:0] drv_l;
  logic [47:0] drv_r;
  logic [47:0] drv_key;

  logic        obs_in_ready;
  logic        obs_out_valid;
  logic        obs_busy;
  logic [47:0] obs_l;
  logic [47:0] obs_r;

  sea_iter_core_if #(.HALF_W(48)) bus_n1 ();
  sea_iter_core_if #(.HALF_W(48)) bus_d  ();
  sea_iter_core_if #(.HALF_W(48)) bus_u4 ();

  assign bus_n1.in_valid  = (sel == 2'd0) && drv_valid;
  assign bus_d.in_valid   = (sel == 2'd1) && drv_valid;
  assign bus_u4.in_valid  = (sel == 2'd2) && drv_valid;
  assign bus_n1.out_ready = (sel == 2'd0) && drv_ready;
  assign bus_d.out_ready  = (sel == 2'd1) && drv_ready;
  assign bus_u4.out_ready = (sel == 2'd2) && drv_ready;
  assign bus_n1.in_mode = drv_mode;
  assign bus_d.in_mode  = drv_mode;
  assign bus_u4.in_mode = drv_mode;
  assign bus_n1.in_l = drv_l;
  assign bus_d.in_l  = drv_l;
  assign bus_u4.in_l = drv_l;
  assign bus_n1.in_r = drv_r;
  assign bus_d.in_r  = drv_r;
  assign bus_u4.in_r = drv_r;
  assign bus_n1.in_key = drv_key;
  assign bus_d.in_key  = drv_key;
  assign bus_u4.in_key = drv_key;

  always_comb begin
    obs_in_ready  = bus_d.in_ready;
    obs_out_valid = bus_d.out_valid;
    obs_busy      = bus_d.busy;
    obs_l         = bus_d.out_l;
    obs_r         = bus_d.out_r;
    if (sel == 2'd0) begin
      obs_in_ready  = bus_n1.in_ready;
      obs_out_valid = bus_n1.out_valid;
      obs_busy      = bus_n1.busy;
      obs_l         = bus_n1.out_l;
      obs_r         = bus_n1.out_r;
    end else if (sel == 2'd2) begin
      obs_in_ready  = bus_u4.in_ready;
      obs_out_valid = bus_u4.out_valid;
      obs_busy      = bus_u4.busy;
      obs_l         = bus_u4.out_l;
      obs_r         = bus_u4.out_r;
    end
  end

  sea_iter_core #(.NUM_ROUNDS(1)) dut_n1 (.clk(clk), .rst(rst), .bus(bus_n1));
  sea_iter_core                   dut_d  (.clk(clk), .rst(rst), .bus(bus_d));
  sea_iter_core #(.UNROLL(4))     dut_u4 (.clk(clk), .rst(rst), .bus(bus_u4));

  // ---------------- reference model (HALF_W=48, WORD_W=8, KEY_ROT=1) -------
  function automatic logic [47:0] m_rotl(input logic [47:0] x, input int n);
    int a;
    a = ((n % 48) + 48) % 48;
    if (a == 0) return x;
    return (x << a) | (x >> (48 - a));
  endfunction

  function automatic logic [2:0] m_s3(input logic [2:0] x);
    case (x)
      3'd0: return 3'd0;
      3'd1: return 3'd5;
      3'd2: return 3'd6;
      3'd3: return 3'd7;
      3'd4: return 3'd4;
      3'd5: return 3'd3;
      3'd6: return 3'd1;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic [47:0] m_s(input logic [47:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[3*i +: 3] = m_s3(x[3*i +: 3]);
    return y;
  endfunction

  function automatic logic [95:0] m_cipher(input logic mode, input logic [47:0] l,
                                           input logic [47:0] r, input logic [47:0] key,
                                           input int nr);
    logic [47:0] a, b, k, t;
    a = l;
    b = r;
    for (int i = 0; i < nr; i++) begin
      if (!mode) begin
        k = m_rotl(key, i);
        t = m_rotl(a, 40) ^ m_rotl(m_s(b ^ k), 1);
        a = b;
        b = t;
      end else begin
        k = m_rotl(key, nr - 1 - i);
        t = m_rotl(m_rotl(m_s(a ^ k), 1) ^ b, 8);
        b = a;
        a = t;
      end
    end
    return {a, b};
  endfunction

  // ---------------- check / drive helpers ----------------------------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] rnd48();
    return 48'({$urandom(), $urandom()});
  endfunction

  // Push one block, measure accept-to-out_valid edges, take the result.
  task automatic run_blk(input logic mode, input logic [47:0] l, input logic [47:0] r,
                         input logic [47:0] key, input int exp_lat,
                         output logic [47:0] ol, output logic [47:0] orr);
    int lat;
    @(negedge clk);
    drv_mode  = mode;
    drv_l     = l;
    drv_r     = r;
    drv_key   = key;
    drv_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble request fields mid-block; the core must not look at them.
    drv_valid = 1'b0;
    drv_mode  = ~mode;
    drv_key   = ~key;
    drv_l     = rnd48();
    drv_r     = rnd48();
    lat = 0;
    while (lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
      if (obs_out_valid) break;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    ol  = obs_l;
    orr = obs_r;
    drv_ready = 1'b1;
    @(posedge clk);
    #1;
    drv_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] ol, orr, el, er, kl, kr, key, l, r, hl, hr;
    logic [95:0] m;
    logic        md;

    sel = 2'd1;
    drv_valid = 1'b0;
    drv_ready = 1'b0;
    drv_mode  = 1'b0;
    drv_l = '0;
    drv_r = '0;
    drv_key = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(obs_in_ready),  64'd1);
    chk("rst_out_valid", 64'(obs_out_valid), 64'd0);
    chk("rst_busy",      64'(obs_busy),      64'd0);
    chk("rst_out_l",     64'(obs_l),         64'd0);
    chk("rst_out_r",     64'(obs_r),         64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(obs_in_ready), 64'd1);

    // Single-round hand vectors
    sel = 2'd0;
    run_blk(1'b1, 48'h1, 48'h0, 48'h0, 1, ol, orr);
    chk("n1_dec_a_l", 64'(ol),  64'h000000000A00);
    chk("n1_dec_a_r", 64'(orr), 64'h1);
    run_blk(1'b1, 48'h0, 48'h1, 48'h0, 1, ol, orr);
    chk("n1_dec_b_l", 64'(ol),  64'h000000000100);
    chk("n1_dec_b_r", 64'(orr), 64'h0);
    run_blk(1'b0, 48'h0, 48'h1, 48'h0, 1, ol, orr);
    chk("n1_enc_l", 64'(ol),  64'h1);
    chk("n1_enc_r", 64'(orr), 64'hA);
    chk("n1_idle_ready", 64'(obs_in_ready), 64'd1);

    // Defaults: encrypt vs model, then decrypt back to plaintext
    sel = 2'd1;
    for (int n = 0; n < 1000; n++) begin
      l   = rnd48();
      r   = rnd48();
      key = rnd48();
      m   = m_cipher(1'b0, l, r, key, 16);
      run_blk(1'b0, l, r, key, 16, el, er);
      chk("enc_l", 64'(el), 64'(m[95:48]));
      chk("enc_r", 64'(er), 64'(m[47:0]));
      run_blk(1'b1, el, er, key, 16, ol, orr);
      chk("dec_l", 64'(ol),  64'(l));
      chk("dec_r", 64'(orr), 64'(r));
    end

    // Back-pressure in DONE
    l = 48'h0123456789AB; r = 48'hFEDCBA987654; key = 48'h00F00F00F00F;
    m = m_cipher(1'b0, l, r, key, 16);
    @(negedge clk);
    drv_mode = 1'b0; drv_l = l; drv_r = r; drv_key = key; drv_valid = 1'b1;
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    chk("run_busy",     64'(obs_busy),     64'd1);
    chk("run_in_ready", 64'(obs_in_ready), 64'd0);
    repeat (16) @(posedge clk);
    #1;
    chk("hold_valid0", 64'(obs_out_valid), 64'd1);
    chk("hold_l0",     64'(obs_l), 64'(m[95:48]));
    chk("hold_r0",     64'(obs_r), 64'(m[47:0]));
    drv_valid = 1'b1; drv_l = 48'hAAAAAAAAAAAA; drv_key = 48'h5;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("hold_valid",    64'(obs_out_valid), 64'd1);
      chk("hold_l",        64'(obs_l), 64'(m[95:48]));
      chk("hold_r",        64'(obs_r), 64'(m[47:0]));
      chk("hold_in_ready", 64'(obs_in_ready), 64'd0);
    end
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    @(posedge clk);
    #1;
    drv_ready = 1'b0;
    chk("release_in_ready",  64'(obs_in_ready),  64'd1);
    chk("release_out_valid", 64'(obs_out_valid), 64'd0);
    chk("release_busy",      64'(obs_busy),      64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_l", 64'(obs_l), 64'(m[95:48]));
    chk("idle_hold_r", 64'(obs_r), 64'(m[47:0]));

    // Reset in the middle of RUN
    @(negedge clk);
    drv_mode = 1'b1; drv_l = rnd48(); drv_r = rnd48(); drv_key = rnd48(); drv_valid = 1'b1;
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(obs_out_valid), 64'd0);
    chk("mid_rst_out_l",     64'(obs_l), 64'd0);
    chk("mid_rst_out_r",     64'(obs_r), 64'd0);
    chk("mid_rst_busy",      64'(obs_busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready",  64'(obs_in_ready),  64'd1);
    chk("mid_rst_valid_rel", 64'(obs_out_valid), 64'd0);
    l = rnd48(); r = rnd48(); key = rnd48();
    m = m_cipher(1'b1, l, r, key, 16);
    run_blk(1'b1, l, r, key, 16, ol, orr);
    chk("after_rst_l", 64'(ol),  64'(m[95:48]));
    chk("after_rst_r", 64'(orr), 64'(m[47:0]));

    // Four rounds per clock
    sel = 2'd2;
    for (int n = 0; n < 20; n++) begin
      md  = n[0];
      l   = rnd48();
      r   = rnd48();
      key = rnd48();
      m   = m_cipher(md, l, r, key, 16);
      run_blk(md, l, r, key, 4, kl, kr);
      chk("u4_l", 64'(kl), 64'(m[95:48]));
      chk("u4_r", 64'(kr), 64'(m[47:0]));
    end
    hl = kl; hr = kr;
    repeat (2) @(posedge clk);
    #1;
    chk("u4_idle_l", 64'(obs_l), 64'(hl));
    chk("u4_idle_r", 64'(obs_r), 64'(hr));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
`default_nettype wire
